// File: rtl/axi4_lite_rw_arbiter.sv
// rtl/axi4_lite_rw_arbiter.sv - round-robin arbiter of AXI4-Lite write/read requests onto one peripheral port
// Optional ACCESS watchdog is compiled in when AXI_ARB_TIMEOUT_EN is defined.
module axi4_lite_rw_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      wr_req,
    input  logic [ADDRESS_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                      rd_req,
    input  logic [ADDRESS_WIDTH-1:0]  rd_addr,
    output logic                      wr_done,
    output logic [1:0]                wr_resp,
    output logic                      rd_done,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [1:0]                rd_resp,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic                      mem_ready,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]               state_q, state_d;

    logic                     wr_pend_q, wr_pend_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [STRB_WIDTH-1:0]    wr_strb_q, wr_strb_d;
    logic                     rd_pend_q, rd_pend_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;

    // last_wr_q: winner of the most recent contended arbitration (1 = write)
    logic                     last_wr_q, last_wr_d;
    logic                     gnt_wr_q, gnt_wr_d;

    logic                     mem_en_q, mem_en_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]    mem_wstrb_q, mem_wstrb_d;

    logic                     wr_done_q, wr_done_d;
    logic [1:0]               wr_resp_q, wr_resp_d;
    logic                     rd_done_q, rd_done_d;
    logic [1:0]               rd_resp_q, rd_resp_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;

    logic                     pick_wr;
    logic                     access_end;
    logic                     access_err;
    logic [DATA_WIDTH-1:0]    rdata_capt;

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
`endif

    // Contended grant goes to the channel that lost the previous contention
    assign pick_wr = wr_pend_q && (!rd_pend_q || !last_wr_q);

    always_comb begin
        state_d     = state_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        last_wr_d   = last_wr_q;
        gnt_wr_d    = gnt_wr_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wr_done_d   = 1'b0;
        wr_resp_d   = wr_resp_q;
        rd_done_d   = 1'b0;
        rd_resp_d   = rd_resp_q;
        rd_data_d   = rd_data_q;
        access_end  = 1'b0;
        access_err  = 1'b0;
        rdata_capt  = mem_rdata;

        case (state_q)
            ST_IDLE: begin
                if (wr_pend_q || rd_pend_q) begin
                    state_d     = ST_ACCESS;
                    gnt_wr_d    = pick_wr;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_wr;
                    mem_addr_d  = pick_wr ? wr_addr_q : rd_addr_q;
                    mem_wdata_d = pick_wr ? wr_data_q : '0;
                    mem_wstrb_d = pick_wr ? wr_strb_q : '0;
                    if (wr_pend_q && rd_pend_q) begin
                        last_wr_d = pick_wr;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ready) begin
                    access_end = 1'b1;
                    access_err = mem_err;
                end
`ifdef AXI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    access_end = 1'b1;
                    access_err = 1'b1;
                    rdata_capt = '0;
                end
`endif
                if (access_end) begin
                    state_d  = ST_COMPLETE;
                    mem_en_d = 1'b0;
                    if (gnt_wr_q) begin
                        wr_pend_d = 1'b0;
                        wr_done_d = 1'b1;
                        wr_resp_d = access_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        rd_pend_d = 1'b0;
                        rd_done_d = 1'b1;
                        rd_resp_d = access_err ? RESP_SLVERR : RESP_OKAY;
                        rd_data_d = rdata_capt;
                    end
                end
            end

            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
            end
        endcase

        // A request for a channel whose pending slot is occupied is dropped
        if (wr_req && !wr_pend_q) begin
            wr_pend_d = 1'b1;
            wr_addr_d = wr_addr;
            wr_data_d = wr_data;
            wr_strb_d = wr_strb;
        end
        if (rd_req && !rd_pend_q) begin
            rd_pend_d = 1'b1;
            rd_addr_d = rd_addr;
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_ACCESS && !access_end) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            last_wr_q   <= 1'b0;
            gnt_wr_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wr_done_q   <= 1'b0;
            wr_resp_q   <= 2'b00;
            rd_done_q   <= 1'b0;
            rd_resp_q   <= 2'b00;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            last_wr_q   <= last_wr_d;
            gnt_wr_q    <= gnt_wr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wr_done_q   <= wr_done_d;
            wr_resp_q   <= wr_resp_d;
            rd_done_q   <= rd_done_d;
            rd_resp_q   <= rd_resp_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign wr_done   = wr_done_q;
    assign wr_resp   = wr_resp_q;
    assign rd_done   = rd_done_q;
    assign rd_resp   = rd_resp_q;
    assign rd_data   = rd_data_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule
